pipe_stage_skid: RTL and testbench

//  - Generic, parametrised inter-stage pipeline register. It replaces per-stage hand-built DFF banks (IF/ID ... MEM/WB).
//  - Adds a valid/ready handshake, a 2-entry skid buffer and a flush (bubble) input.
//  - Sits between any two pipeline stages. Lets a downstream stall back-pressure upstream with no combinational ready path.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_skid.sv | 178 +++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid stage.
package pipe_pkg;

  // Occupancy of the stage: main slot only, or main plus skid slot.
  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_FULL,
    PS_SKID
  } pipe_state_e;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 32;

  // The stage can take a new beat unless both slots are occupied.
  function automatic logic pipe_can_accept(input pipe_state_e st);
    return (st != PS_SKID);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One {valid, data, ctrl} storage slot with load and clear enables.
// Clear only drops the valid bit; the payload keeps its last value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  // Slot register: clear wins over load so a flush always empties the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      ctrl_reg  <= in_ctrl;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// a 2-entry skid buffer and a flush input. up_ready comes from a flop so
// downstream stalls never form a combinational path back upstream.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = PIPE_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  pipe_state_e state_reg, state_next;
  logic        up_ready_reg;

  logic              up_fire, dn_fire;
  logic              m_load, m_clear, m_from_s;
  logic              s_load, s_clear;
  logic [DATA_W-1:0] m_in_data;
  logic [CTRL_W-1:0] m_in_ctrl;

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;

  assign up_fire = up_valid & up_ready_reg;
  assign dn_fire = m_valid & dn_ready;

  // State and registered ready: ready for next cycle follows next occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= PS_EMPTY;
      up_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      up_ready_reg <= pipe_can_accept(state_next);
    end
  end

  // Next-state and slot enables; flush overrides every handshake transition.
  always_comb begin
    state_next = state_reg;
    m_load     = 1'b0;
    m_clear    = 1'b0;
    m_from_s   = 1'b0;
    s_load     = 1'b0;
    s_clear    = 1'b0;
    if (flush) begin
      state_next = PS_EMPTY;
      m_clear    = 1'b1;
      s_clear    = 1'b1;
    end else begin
      case (state_reg)
        PS_EMPTY: begin
          if (up_fire) begin
            state_next = PS_FULL;
            m_load     = 1'b1;
          end
        end
        PS_FULL: begin
          if (up_fire && dn_fire) begin
            m_load = 1'b1;
          end else if (up_fire) begin
            state_next = PS_SKID;
            s_load     = 1'b1;
          end else if (dn_fire) begin
            state_next = PS_EMPTY;
            m_clear    = 1'b1;
          end
        end
        PS_SKID: begin
          if (dn_fire) begin
            state_next = PS_FULL;
            m_load     = 1'b1;
            m_from_s   = 1'b1;
            s_clear    = 1'b1;
          end
        end
        default: begin
          state_next = PS_EMPTY;
          m_clear    = 1'b1;
          s_clear    = 1'b1;
        end
      endcase
    end
  end

  // Main slot refills from the skid slot when draining, else from upstream.
  always_comb begin
    m_in_data = up_data;
    m_in_ctrl = up_ctrl;
    if (m_from_s) begin
      m_in_data = s_data;
      m_in_ctrl = s_ctrl;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_slot_m (
    .clk     (clk),
    .reset   (reset),
    .load    (m_load),
    .clear   (m_clear),
    .in_data (m_in_data),
    .in_ctrl (m_in_ctrl),
    .valid   (m_valid),
    .data    (m_data),
    .ctrl    (m_ctrl)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_slot_s (
    .clk     (clk),
    .reset   (reset),
    .load    (s_load),
    .clear   (s_clear),
    .in_data (up_data),
    .in_ctrl (up_ctrl),
    .valid   (s_valid),
    .data    (s_data),
    .ctrl    (s_ctrl)
  );

  // s_valid mirrors the SKID state; kept for visibility in debug only.
  logic unused_s_valid;
  assign unused_s_valid = s_valid;

  assign up_ready = up_ready_reg;
  assign dn_valid = m_valid;
  assign dn_data  = m_data;
  assign dn_ctrl  = m_valid ? m_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Saturating counters of stalled and empty output cycles; flush leaves them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (m_valid && !dn_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (!m_valid && (bubble_cnt_reg != {CNT_W{1'b1}}))
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid. Inputs change on the falling
// edge and outputs are checked on the falling edge, away from the rising
// edge where state updates.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        up_valid;
  logic        up_ready;
  logic [63:0] up_data;
  logic [7:0]  up_ctrl;
  logic        dn_valid;
  logic        dn_ready;
  logic [63:0] dn_data;
  logic [7:0]  dn_ctrl;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic        up_ready2, dn_valid2;
  logic [63:0] dn_data2;
  logic [7:0]  dn_ctrl2;
  logic [1:0]  stall_cnt2, bubble_cnt2;
`endif

  pipe_stage_skid dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_ctrl    (up_ctrl),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_data    (dn_data),
    .dn_ctrl    (dn_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_skid #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .up_valid   (up_valid),
    .up_ready   (up_ready2),
    .up_data    (up_data),
    .up_ctrl    (up_ctrl),
    .dn_valid   (dn_valid2),
    .dn_ready   (dn_ready),
    .dn_data    (dn_data2),
    .dn_ctrl    (dn_ctrl2),
    .stall_cnt  (stall_cnt2),
    .bubble_cnt (bubble_cnt2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    flush    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    up_ctrl  = '0;
    dn_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b exp 1", up_ready); end
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %b exp 0", dn_valid); end
    checks++; if (dn_data !== 64'h0) begin errors++; $display("FAIL reset_dn_data got %h exp 0", dn_data); end
    checks++; if (dn_ctrl !== 8'h0) begin errors++; $display("FAIL reset_dn_ctrl got %h exp 0", dn_ctrl); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (up_ready !== 1'b1 || dn_valid !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", up_ready, dn_valid); end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    dn_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1;
      up_data  = 64'(i);
      up_ctrl  = 8'(8'h40 + i);
      @(negedge clk);
      checks++; if (dn_valid !== 1'b1 || dn_data !== 64'(i)) begin errors++; $display("FAIL stream_beat%0d got vld=%b data=%h exp vld=1 data=%h", i, dn_valid, dn_data, 64'(i)); end
      checks++; if (dn_ctrl !== 8'(8'h40 + i) || up_ready !== 1'b1) begin errors++; $display("FAIL stream_ctrl%0d got ctrl=%h rdy=%b exp ctrl=%h rdy=1", i, dn_ctrl, up_ready, 8'(8'h40 + i)); end
      $display("stream beat %0d out data=%h", i, dn_data);
    end
    up_valid = 1'b0;
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got vld=%b exp 0", dn_valid); end
  endtask

  task automatic test_ctrl_zero();
    dn_ready = 1'b1;
    up_valid = 1'b1; up_data = 64'h55; up_ctrl = 8'h3C;
    @(negedge clk);
    checks++; if (dn_ctrl !== 8'h3C || dn_data !== 64'h55) begin errors++; $display("FAIL ctrl_load got ctrl=%h data=%h exp ctrl=3c data=55", dn_ctrl, dn_data); end
    up_valid = 1'b0; up_ctrl = 8'hFF; up_data = 64'hDEAD;
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL ctrl_zero_vld got %b exp 0", dn_valid); end
    checks++; if (dn_ctrl !== 8'h00) begin errors++; $display("FAIL ctrl_zero_ctrl got %h exp 00", dn_ctrl); end
    checks++; if (dn_data !== 64'h55) begin errors++; $display("FAIL ctrl_zero_data got %h exp 55", dn_data); end
    $display("ctrl zero: ctrl=%h data=%h", dn_ctrl, dn_data);
  endtask

  task automatic test_back_pressure();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 64'h10; up_ctrl = 8'h1;
    @(negedge clk);
    checks++; if (up_ready !== 1'b1 || dn_data !== 64'h10) begin errors++; $display("FAIL bp_first got rdy=%b data=%h exp rdy=1 data=10", up_ready, dn_data); end
    up_data = 64'h11; up_ctrl = 8'h2;
    @(negedge clk);
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b exp 0", up_ready); end
    up_data = 64'h12; up_ctrl = 8'h3;
    @(negedge clk);
    checks++; if (up_ready !== 1'b0 || dn_data !== 64'h10 || dn_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=10", up_ready, dn_valid, dn_data); end
    dn_ready = 1'b1;
    @(negedge clk);
    checks++; if (dn_valid !== 1'b1 || dn_data !== 64'h11 || dn_ctrl !== 8'h2) begin errors++; $display("FAIL bp_out2 got vld=%b data=%h ctrl=%h exp vld=1 data=11 ctrl=02", dn_valid, dn_data, dn_ctrl); end
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", up_ready); end
    @(negedge clk);
    up_valid = 1'b0;
    checks++; if (dn_valid !== 1'b1 || dn_data !== 64'h12) begin errors++; $display("FAIL bp_out3 got vld=%b data=%h exp vld=1 data=12", dn_valid, dn_data); end
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got vld=%b data=%h exp vld=0", dn_valid, dn_data); end
    $display("back pressure: 10, 11, 12 delivered in order");
  endtask

  task automatic test_flush_skid();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 64'h30; up_ctrl = 8'h7;
    @(negedge clk);
    up_data = 64'h31;
    @(negedge clk);
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got rdy=%b exp 0", up_ready); end
    flush = 1'b1; up_data = 64'h20; up_ctrl = 8'h9;
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0 || dn_ctrl !== 8'h0) begin errors++; $display("FAIL flush_out got vld=%b ctrl=%h exp vld=0 ctrl=00", dn_valid, dn_ctrl); end
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", up_ready); end
    // second flush cycle with a beat offered: still empty
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0 || up_ready !== 1'b1) begin errors++; $display("FAIL flush_b2b got vld=%b rdy=%b exp vld=0 rdy=1", dn_valid, up_ready); end
    flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got vld=%b data=%h exp vld=0", dn_valid, dn_data); end
    up_valid = 1'b1; up_data = 64'h21; up_ctrl = 8'h4;
    @(negedge clk);
    up_valid = 1'b0;
    checks++; if (dn_valid !== 1'b1 || dn_data !== 64'h21) begin errors++; $display("FAIL flush_recover got vld=%b data=%h exp vld=1 data=21", dn_valid, dn_data); end
    @(negedge clk);
    $display("flush in skid: 20 dropped, 21 delivered");
  endtask

  task automatic test_reset_mid_skid();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 64'hA; up_ctrl = 8'h5;
    @(negedge clk);
    up_data = 64'hB; up_ctrl = 8'h6;
    @(negedge clk);
    checks++; if (up_ready !== 1'b0 || dn_data !== 64'hA) begin errors++; $display("FAIL rskid_fill got rdy=%b data=%h exp rdy=0 data=a", up_ready, dn_data); end
    up_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (dn_valid !== 1'b0 || dn_ctrl !== 8'h0) begin errors++; $display("FAIL rskid_async got vld=%b ctrl=%h exp vld=0 ctrl=00", dn_valid, dn_ctrl); end
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rskid_ready got %b exp 1", up_ready); end
    @(negedge clk);
    reset = 1'b1;
    up_valid = 1'b1; up_data = 64'hC; up_ctrl = 8'h8; dn_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    checks++; if (dn_valid !== 1'b1 || dn_data !== 64'hC || dn_ctrl !== 8'h8) begin errors++; $display("FAIL rskid_new got vld=%b data=%h ctrl=%h exp vld=1 data=c ctrl=08", dn_valid, dn_data, dn_ctrl); end
    @(negedge clk);
    checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL rskid_only_c got vld=%b data=%h exp vld=0", dn_valid, dn_data); end
    $display("reset mid skid: beat c delivered after release");
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    // The cycle in which the first beat is captured counts as a bubble,
    // so bubble_cnt ends at 1 + 3 idle cycles.
    reset = 1'b0;
    idle_inputs();
    up_valid = 1'b1; up_data = 64'h77;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd1) begin errors++; $display("FAIL perf_start got stall=%0d bubble=%0d exp 0 1", stall_cnt, bubble_cnt); end
    repeat (5) @(negedge clk);
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall got %0d exp 5", stall_cnt); end
    dn_ready = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd4) begin errors++; $display("FAIL perf_bubble got stall=%0d bubble=%0d exp 5 4", stall_cnt, bubble_cnt); end
    checks++; if (stall_cnt2 !== 2'd3 || bubble_cnt2 !== 2'd3) begin errors++; $display("FAIL perf_sat got stall=%0d bubble=%0d exp 3 3", stall_cnt2, bubble_cnt2); end
    $display("perf: stall=%0d bubble=%0d sat stall=%0d bubble=%0d", stall_cnt, bubble_cnt, stall_cnt2, bubble_cnt2);
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_ctrl_zero();
    test_back_pressure();
    test_flush_skid();
    test_reset_mid_skid();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
